// File: rtl/beep_arb_pkg.sv
// Shared types and helpers for the two-requester buzzer arbiter.
package beep_arb_pkg;

  localparam int N_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_e;

  // Number of beeps in the pattern belonging to requester idx.
  function automatic logic [2:0] beeps_for(input logic       idx,
                                           input logic [2:0] beeps0,
                                           input logic [2:0] beeps1);
    return idx ? beeps1 : beeps0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: combinational one-hot take from pending bits and last winner.
module rr_arb2 (
  input  logic [1:0] pend_i,
  input  logic       last_i,
  output logic [1:0] take_o
);

  always_comb begin
    take_o = 2'b00;
    case (pend_i)
      2'b01:   take_o = 2'b01;
      2'b10:   take_o = 2'b10;
      // Both pending: the requester that did not win last time goes next.
      2'b11:   take_o = last_i ? 2'b01 : 2'b10;
      default: take_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/beep_req_arbiter.sv
// Latches buzzer requests from two sources, grants round-robin and plays the owner's beep pattern.
module beep_req_arbiter
  import beep_arb_pkg::*;
#(
  parameter int               CNT_W   = 24,
  parameter logic [CNT_W-1:0] ON_CNT  = 24'd5_000_000,
  parameter logic [CNT_W-1:0] OFF_CNT = 24'd2_500_000,
  parameter logic [CNT_W-1:0] GAP_CNT = 24'd5_000_000,
  parameter logic [2:0]       BEEPS0  = 3'd1,
  parameter logic [2:0]       BEEPS1  = 3'd2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             done,
  output logic             beep
);

  localparam logic [CNT_W-1:0] ON_LAST  = ON_CNT  - 1'b1;
  localparam logic [CNT_W-1:0] OFF_LAST = OFF_CNT - 1'b1;
  localparam logic [CNT_W-1:0] GAP_LAST = GAP_CNT - 1'b1;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   pend_q, pend_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         beeps_left_q, beeps_left_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               busy_q, done_q, beep_q;
  logic [N_REQ-1:0]   take, take_eff;

  rr_arb2 u_rr_arb2 (
    .pend_i (pend_q),
    .last_i (last_q),
    .take_o (take)
  );

  // NOTE: every variable gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    beeps_left_d = beeps_left_q;
    grant_d      = grant_q;
    last_d       = last_q;
    take_eff     = '0;
    case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          take_eff     = take;
          grant_d      = take;
          last_d       = take[1];
          beeps_left_d = beeps_for(take[1], BEEPS0, BEEPS1) - 3'd1;
          cnt_d        = '0;
          state_d      = ON;
        end
      end
      ON: begin
        if (cnt_q == ON_LAST) begin
          cnt_d = '0;
          if (beeps_left_q != 3'd0) begin
            beeps_left_d = beeps_left_q - 3'd1;
            state_d      = OFF;
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OFF: begin
        if (cnt_q == OFF_LAST) begin
          cnt_d   = '0;
          state_d = ON;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A req coinciding with its own take survives the clear and is replayed later.
    pend_d = (pend_q & ~take_eff) | req;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      last_q       <= 1'b1;
      cnt_q        <= '0;
      beeps_left_q <= 3'd0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      beep_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      beeps_left_q <= beeps_left_d;
      grant_q      <= grant_d;
      // Outputs are registered from next-state so they line up with state_q.
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == GAP) && (cnt_d == GAP_LAST);
      beep_q       <= (state_d == ON);
    end
  end

  always_ff @(posedge sys_clk) begin
    param_ok: assert (ON_CNT != '0 && OFF_CNT != '0 && GAP_CNT != '0 &&
                      BEEPS0 != 3'd0 && BEEPS1 != 3'd0)
      else $error("beep_req_arbiter: zero-valued count parameter");
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign beep  = beep_q;

endmodule

// File: tb/tb_beep_req_arbiter.sv
// Randomized and directed bench for beep_req_arbiter against a pattern-position reference model.
module tb_beep_req_arbiter;

  localparam int ON_C  = 4;
  localparam int OFF_C = 3;
  localparam int GAP_C = 5;
  localparam int B0    = 1;
  localparam int B1    = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [1:0] req     = 2'b00;
  logic [1:0] grant;
  logic       busy, done, beep;

  beep_req_arbiter #(
    .CNT_W   (24),
    .ON_CNT  (24'd4),
    .OFF_CNT (24'd3),
    .GAP_CNT (24'd5),
    .BEEPS0  (3'd1),
    .BEEPS1  (3'd2)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .req     (req),
    .grant   (grant),
    .busy    (busy),
    .done    (done),
    .beep    (beep)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending set, last winner, owner, and position t within the owner's pattern.
  logic [1:0] m_pend  = 2'b00;
  int         m_last  = 1;
  int         m_owner = 0;
  int         m_t     = -1;

  function automatic int n_of(input int i);
    return (i == 1) ? B1 : B0;
  endfunction
  function automatic int active_of(input int i);
    return ON_C * n_of(i) + OFF_C * (n_of(i) - 1);
  endfunction
  function automatic int len_of(input int i);
    return active_of(i) + GAP_C;
  endfunction

  task automatic model_step(input logic [1:0] r, input logic rst);
    logic [1:0] taken;
    taken = 2'b00;
    if (rst) begin
      m_pend = 2'b00;
      m_last = 1;
      m_t    = -1;
    end else begin
      if (m_t >= 0) begin
        m_t++;
        if (m_t == len_of(m_owner)) m_t = -1;
      end else if (m_pend != 2'b00) begin
        if (m_pend == 2'b11) m_owner = 1 - m_last;
        else                 m_owner = m_pend[1] ? 1 : 0;
        m_last = m_owner;
        m_t    = 0;
        taken  = (m_owner == 1) ? 2'b10 : 2'b01;
      end
      m_pend = (m_pend & ~taken) | r;
    end
  endtask

  // Tallies over a directed window.
  int         t_busy, t_beep, t_done, t_g0, t_g1, t_any;
  logic [1:0] prev_grant = 2'b00;
  logic [1:0] gseq[$];

  task automatic clear_tally();
    t_busy = 0; t_beep = 0; t_done = 0; t_g0 = 0; t_g1 = 0; t_any = 0;
    gseq.delete();
  endtask

  task automatic cycle(input logic [1:0] r, input logic rst = 1'b0);
    logic [1:0] e_grant;
    logic       e_busy, e_done, e_beep;
    int         p;
    @(negedge sys_clk);
    req     = r;
    sys_rst = rst;
    @(posedge sys_clk);
    model_step(r, rst);
    #1;
    e_busy  = (m_t >= 0);
    e_grant = !e_busy ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
    e_done  = e_busy && (m_t == len_of(m_owner) - 1);
    p       = e_busy ? (m_t % (ON_C + OFF_C)) : 0;
    e_beep  = e_busy && (m_t < active_of(m_owner)) && (p < ON_C);
    check("outputs{grant,busy,done,beep}", {27'd0, grant, busy, done, beep},
          {27'd0, e_grant, e_busy, e_done, e_beep});
    t_busy += int'(busy);
    t_beep += int'(beep);
    t_done += int'(done);
    t_g0   += int'(grant == 2'b01);
    t_g1   += int'(grant == 2'b10);
    t_any  += int'(busy || beep || done || grant != 2'b00);
    if (grant != 2'b00 && prev_grant == 2'b00) gseq.push_back(grant);
    prev_grant = grant;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(2'b00);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cycle(2'b00, 1'b1);
  endtask

  initial begin
    // Reset held with req toggling; nothing may leak out or stay pending.
    clear_tally();
    for (int i = 0; i < 10; i++) cycle((i % 2 == 0) ? 2'b11 : 2'b01, 1'b1);
    check("rst_hold_outputs", t_any, 0);
    clear_tally();
    idle(6);
    check("rst_release_quiet", t_any, 0);

    // Requester 0 alone.
    clear_tally();
    cycle(2'b01);
    idle(12);
    check("r0_busy", t_busy, ON_C + GAP_C);
    check("r0_beep", t_beep, ON_C);
    check("r0_done", t_done, 1);
    check("r0_grant", t_g0, ON_C + GAP_C);

    // Requester 1 alone.
    clear_tally();
    cycle(2'b10);
    idle(20);
    check("r1_busy", t_busy, 2 * ON_C + OFF_C + GAP_C);
    check("r1_beep", t_beep, 2 * ON_C);
    check("r1_done", t_done, 1);
    check("r1_grant", t_g1, 2 * ON_C + OFF_C + GAP_C);

    // Both at once straight after reset, then again.
    do_reset();
    clear_tally();
    cycle(2'b11);
    idle(30);
    check("both_busy", t_busy, 25);
    check("both_order_n", gseq.size(), 2);
    if (gseq.size() == 2) begin
      check("both_first", gseq[0], 2'b01);
      check("both_second", gseq[1], 2'b10);
    end
    clear_tally();
    cycle(2'b11);
    idle(30);
    check("both2_n", gseq.size(), 2);
    if (gseq.size() == 2) check("both2_first", gseq[0], 2'b01);

    // Three repeated requests during own ON phase collapse into one replay.
    clear_tally();
    cycle(2'b01);
    cycle(2'b00);
    cycle(2'b01);
    cycle(2'b01);
    cycle(2'b01);
    idle(25);
    check("replay_patterns", gseq.size(), 2);
    check("replay_busy", t_busy, 18);
    check("replay_done", t_done, 2);

    // Asynchronous reset mid-ON with another request pending.
    cycle(2'b01);
    cycle(2'b00);
    cycle(2'b10);
    cycle(2'b00);
    check("pre_async_beep", beep, 1'b1);
    #2;
    sys_rst = 1'b1;
    #1;
    check("async_rst_outputs", {grant, busy, beep}, 4'b0000);
    for (int i = 0; i < 3; i++) cycle(2'b00, 1'b1);
    clear_tally();
    idle(25);
    check("post_rst_quiet", t_any, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] r;
      logic       rs;
      r[0] = ($urandom_range(0, 9) == 0);
      r[1] = ($urandom_range(0, 9) == 0);
      rs   = ($urandom_range(0, 399) == 0);
      cycle(r, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
